// File: rtl/bit_serializer.sv
// Word-to-bit serializer: one holding buffer feeding an MSB-first shifter.
// Optional even-parity trailer bit enabled by SERIALIZER_PARITY_EN.
module bit_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_PERIOD = 1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  serial_out,
    output logic                  shift_active,
    output logic                  word_done
);

`ifdef SERIALIZER_PARITY_EN
    localparam int WORD_LEN = DATA_WIDTH + 1;
`else
    localparam int WORD_LEN = DATA_WIDTH;
`endif

    localparam int CW = $clog2(WORD_LEN);
    localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WORD_LEN - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(BIT_PERIOD - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic [DATA_WIDTH-1:0]   buf_data;
    logic                    buf_full;
    logic [WORD_LEN-1:0]     sreg;
    logic [WORD_LEN-1:0]     load_word;
    logic [CW-1:0]           bit_cnt;
    logic [TW-1:0]           timer;
    logic                    accept;
    logic                    load;
    logic                    tick;
    logic                    last;

`ifdef SERIALIZER_PARITY_EN
    assign load_word = {buf_data, ^buf_data};
`else
    assign load_word = buf_data;
`endif

    assign data_ready = !buf_full;
    assign accept     = data_valid && data_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        load         = 1'b0;
        tick         = 1'b0;
        last         = 1'b0;
        serial_out   = 1'b0;
        shift_active = 1'b0;
        word_done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (buf_full) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                shift_active = 1'b1;
                serial_out   = sreg[WORD_LEN-1];
                tick         = (timer == TMR_LAST);
                last         = tick && (bit_cnt == CNT_LAST);
                word_done    = last;
                // Reload on the final edge keeps the stream gap-free
                if (last) begin
                    if (buf_full) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sreg    <= '0;
            bit_cnt <= '0;
            timer   <= '0;
        end else if (load) begin
            sreg    <= load_word;
            bit_cnt <= '0;
            timer   <= '0;
        end else if (last) begin
            sreg    <= '0;
            bit_cnt <= '0;
            timer   <= '0;
        end else if (state == SHIFT) begin
            if (tick) begin
                timer   <= '0;
                sreg    <= {sreg[WORD_LEN-2:0], 1'b0};
                bit_cnt <= bit_cnt + CW'(1);
            end else begin
                timer <= timer + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            buf_data <= '0;
            buf_full <= 1'b0;
        end else begin
            if (accept) begin
                buf_data <= data_in;
            end
            buf_full <= accept || (buf_full && !load);
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: per-cycle expected-output queue built from
// accepted words, compared against every DUT output each cycle.
module tb_bit_serializer;

    localparam int DW = 4;
    localparam int BP = 3;
`ifdef SERIALIZER_PARITY_EN
    localparam int WL = DW + 1;
`else
    localparam int WL = DW;
`endif

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic          serial_out;
    logic          shift_active;
    logic          word_done;

    int nvec = 0;
    int nerr = 0;

    // one entry per future output cycle: {serial bit, word_done}
    logic [1:0]    q[$];
    logic          mfull = 1'b0;
    logic [DW-1:0] mbuf = '0;

    bit_serializer #(
        .DATA_WIDTH(DW),
        .BIT_PERIOD(BP)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .serial_out  (serial_out),
        .shift_active(shift_active),
        .word_done   (word_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic es;
        logic ed;
        es = (q.size() != 0) ? q[0][1] : 1'b0;
        ed = (q.size() != 0) ? q[0][0] : 1'b0;
        chk("serial_out", serial_out, es);
        chk("word_done", word_done, ed);
        chk("shift_active", shift_active, q.size() != 0);
        chk("data_ready", data_ready, !mfull);
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        logic [WL-1:0] w;
`ifdef SERIALIZER_PARITY_EN
        w = {d, ^d};
`else
        w = d;
`endif
        for (int b = WL - 1; b >= 0; b--) begin
            for (int t = 0; t < BP; t++) begin
                q.push_back({w[b], (b == 0 && t == BP - 1)});
            end
        end
    endtask

    task automatic model_edge();
        logic acc;
        int   n;
        acc = data_valid && !mfull;
        n   = q.size();
        if (n > 0) void'(q.pop_front());
        if (mfull && n <= 1) begin
            push_word(mbuf);
            mfull = 1'b0;
        end
        if (acc) begin
            mfull = 1'b1;
            mbuf  = data_in;
        end
    endtask

    task automatic cycle(input logic v, input logic [DW-1:0] d);
        @(negedge clk);
        check_all();
        data_valid = v;
        data_in    = d;
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_all();
        n_rst = 1'b1;
        repeat (2) cycle(1'b0, '0);

        // single word
        cycle(1'b1, 4'b1101);
        repeat (20) cycle(1'b0, '0);

        // back-to-back with valid held high
        cycle(1'b1, 4'b1101);
        repeat (14) cycle(1'b1, 4'b0110);
        repeat (20) cycle(1'b0, '0);

        // backpressure: data changes while not ready
        repeat (40) cycle(1'b1, DW'($urandom));
        repeat (20) cycle(1'b0, '0);

        // boundary words
        cycle(1'b1, 4'b0000);
        cycle(1'b1, 4'b1111);
        repeat (30) cycle(1'b0, '0);

        // random traffic
        repeat (400) cycle(1'($urandom_range(0, 1)), DW'($urandom));
        repeat (20) cycle(1'b0, '0);

        // reset mid-word with a second word buffered
        cycle(1'b1, 4'b1111);
        cycle(1'b0, '0);
        cycle(1'b1, 4'b1010);
        repeat (3) cycle(1'b0, '0);
        @(negedge clk);
        data_valid = 1'b0;
        n_rst      = 1'b0;
        #1;
        q.delete();
        mfull = 1'b0;
        check_all();
        @(negedge clk);
        check_all();
        n_rst = 1'b1;
        repeat (10) cycle(1'b0, '0);
        cycle(1'b1, 4'b0101);
        repeat (20) cycle(1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
